// File: rtl/cond_execute_stage_pkg.sv
// Shared types for the execute-stage condition unit:
// condition codes, flag indices and the registered control bundle.
package cond_execute_stage_pkg;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0,
    CC_NE = 4'h1,
    CC_CS = 4'h2,
    CC_CC = 4'h3,
    CC_MI = 4'h4,
    CC_PL = 4'h5,
    CC_VS = 4'h6,
    CC_VC = 4'h7,
    CC_HI = 4'h8,
    CC_LS = 4'h9,
    CC_GE = 4'hA,
    CC_LT = 4'hB,
    CC_GT = 4'hC,
    CC_LE = 4'hD,
    CC_AL = 4'hE,
    CC_NV = 4'hF
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef struct packed {
    logic       valid;
    logic [3:0] cond;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       memtoreg;
    logic       alusrc;
    logic       nowrite;
    logic       shift;
    logic [1:0] flagw;
    logic [2:0] alucontrol;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/cond_execute_stage_cond_check.sv
// Evaluates a 4-bit condition field against {N,Z,C,V}.
// NV is executed as always-true in this core.
module cond_check
  import cond_execute_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  cond_e c;
  logic  n, z, cf, v;

  assign c  = cond_e'(cond);
  assign n  = flags[FLAG_N];
  assign z  = flags[FLAG_Z];
  assign cf = flags[FLAG_C];
  assign v  = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    unique case (c)
      CC_EQ: pass = z;
      CC_NE: pass = !z;
      CC_CS: pass = cf;
      CC_CC: pass = !cf;
      CC_MI: pass = n;
      CC_PL: pass = !n;
      CC_VS: pass = v;
      CC_VC: pass = !v;
      CC_HI: pass = cf && !z;
      CC_LS: pass = !cf || z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = !z && (n == v);
      CC_LE: pass = z || (n != v);
      CC_AL: pass = 1'b1;
      CC_NV: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_execute_stage.sv
// Decode/execute control register, NZCV flags and condition gating
// of the register, memory and PC write enables.
module cond_execute_stage
  import cond_execute_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall_d,
  input  logic       flush_e,
  input  logic [3:0] cond_d,
  input  logic       pcs_d,
  input  logic       regw_d,
  input  logic       memw_d,
  input  logic       memtoreg_d,
  input  logic       alusrc_d,
  input  logic       nowrite_d,
  input  logic       shift_d,
  input  logic [1:0] flagw_d,
  input  logic [2:0] alucontrol_d,
  input  logic [3:0] aluflags_e,
  output logic       memtoreg_e,
  output logic       alusrc_e,
  output logic       shift_e,
  output logic [2:0] alucontrol_e,
  output logic       condex_e,
  output logic       pcsrc_e,
  output logic       regwrite_e,
  output logic       memwrite_e,
  output logic [3:0] flags
);

  ctrl_t      ctrl_d, ctrl_q;
  logic [3:0] flags_d, flags_q;
  logic       cond_pass;

  cond_check u_cond_check (
    .cond  (ctrl_q.cond),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  always_comb begin
    ctrl_d = ctrl_q;
    if (flush_e) begin
      ctrl_d = CTRL_BUBBLE;
    end else if (!stall_d) begin
      ctrl_d.valid      = 1'b1;
      ctrl_d.cond       = cond_d;
      ctrl_d.pcs        = pcs_d;
      ctrl_d.regw       = regw_d;
      ctrl_d.memw       = memw_d;
      ctrl_d.memtoreg   = memtoreg_d;
      ctrl_d.alusrc     = alusrc_d;
      ctrl_d.nowrite    = nowrite_d;
      ctrl_d.shift      = shift_d;
      ctrl_d.flagw      = flagw_d;
      ctrl_d.alucontrol = alucontrol_d;
    end
  end

  assign condex_e = ctrl_q.valid & cond_pass;

  // N,Z and C,V are written independently
  always_comb begin
    flags_d = flags_q;
    if (condex_e && ctrl_q.flagw[1])
      flags_d[3:2] = aluflags_e[3:2];
    if (condex_e && ctrl_q.flagw[0])
      flags_d[1:0] = aluflags_e[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= CTRL_BUBBLE;
      flags_q <= 4'b0000;
    end else begin
      ctrl_q  <= ctrl_d;
      flags_q <= flags_d;
    end
  end

  assign pcsrc_e      = ctrl_q.pcs & condex_e;
  assign regwrite_e   = ctrl_q.regw & ~ctrl_q.nowrite & condex_e;
  assign memwrite_e   = ctrl_q.memw & condex_e;
  assign memtoreg_e   = ctrl_q.memtoreg;
  assign alusrc_e     = ctrl_q.alusrc;
  assign shift_e      = ctrl_q.shift;
  assign alucontrol_e = ctrl_q.alucontrol;
  assign flags        = flags_q;

endmodule
